// File: rtl/control_sequencer_if.sv
// Opcode, step-control and control-word bundle between the SAP-1 sequencer and the datapath or bench.
interface control_sequencer_if;
  logic [3:0] opcode;
  logic       step_en;
  logic       step;
  logic       cp;
  logic       ep;
  logic       lm;
  logic       ce;
  logic       li;
  logic       ei;
  logic       la;
  logic       ea;
  logic       su;
  logic       eu;
  logic       lb;
  logic       lo;
  logic [5:0] tstate;
  logic       halt;

  modport master (
    input  opcode, step_en, step,
    output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, tstate, halt
  );

  modport slave (
    output opcode, step_en, step,
    input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, tstate, halt
  );
endinterface

// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer: a six-state one-hot ring (T1..T6) with an opcode decoder.
// It adds sticky halt and edge-triggered single-step control.
//
// state | meaning
// T1    | PC onto bus, MAR load
// T2    | PC increment
// T3    | RAM onto bus, IR load
// T4    | LDA/ADD/SUB: IR address to MAR; OUT: ACC to OUT; HLT: halt sets
// T5    | LDA: RAM to ACC; ADD/SUB: RAM to B
// T6    | ADD/SUB: ALU result to ACC
module control_sequencer (
  input  logic                  clk,
  input  logic                  clr,
  control_sequencer_if.master   bus
);
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [5:0] tstate_q, tstate_d;
  logic       halt_q, halt_d;
  logic       step_q;
  logic       advance;

  logic cp_w, ep_w, lm_w, ce_w, li_w, ei_w, la_w, ea_w, su_w, eu_w, lb_w, lo_w;
  logic is_lda, is_add, is_sub, is_out, is_hlt;
  logic active, strobe_ok;

  assign is_lda = (bus.opcode == OP_LDA);
  assign is_add = (bus.opcode == OP_ADD);
  assign is_sub = (bus.opcode == OP_SUB);
  assign is_out = (bus.opcode == OP_OUT);
  assign is_hlt = (bus.opcode == OP_HLT);

  // One advance per cycle in free run; in step mode only on a fresh rising step.
  assign advance = !halt_q && (!bus.step_en || (bus.step && !step_q));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tstate_q <= 6'b000001;
      halt_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halt_q   <= halt_d;
      step_q   <= bus.step;
    end
  end

  always_comb begin
    tstate_d = tstate_q;
    halt_d   = halt_q;
    if (advance) begin
      if (tstate_q[3] && is_hlt) begin
        halt_d = 1'b1;
      end else begin
        tstate_d = {tstate_q[4:0], tstate_q[5]};
      end
    end
  end

  always_comb begin
    cp_w = 1'b0; ep_w = 1'b0; lm_w = 1'b0; ce_w = 1'b0;
    li_w = 1'b0; ei_w = 1'b0; la_w = 1'b0; ea_w = 1'b0;
    su_w = 1'b0; eu_w = 1'b0; lb_w = 1'b0; lo_w = 1'b0;
    case (1'b1)
      tstate_q[0]: begin
        ep_w = 1'b1;
        lm_w = 1'b1;
      end
      tstate_q[1]: cp_w = 1'b1;
      tstate_q[2]: begin
        ce_w = 1'b1;
        li_w = 1'b1;
      end
      tstate_q[3]: begin
        lm_w = is_lda || is_add || is_sub;
        ei_w = is_lda || is_add || is_sub;
        ea_w = is_out;
        lo_w = is_out;
      end
      tstate_q[4]: begin
        ce_w = is_lda || is_add || is_sub;
        la_w = is_lda;
        lb_w = is_add || is_sub;
      end
      tstate_q[5]: begin
        la_w = is_add || is_sub;
        su_w = is_sub;
        eu_w = is_add || is_sub;
      end
      default: ;
    endcase
  end

  // Bus enables hold for the whole state; load strobes fire only when the ring moves.
  assign active    = !clr && !halt_q;
  assign strobe_ok = active && advance;

  assign bus.cp     = cp_w & strobe_ok;
  assign bus.lm     = lm_w & strobe_ok;
  assign bus.li     = li_w & strobe_ok;
  assign bus.la     = la_w & strobe_ok;
  assign bus.lb     = lb_w & strobe_ok;
  assign bus.lo     = lo_w & strobe_ok;
  assign bus.ep     = ep_w & active;
  assign bus.ce     = ce_w & active;
  assign bus.ei     = ei_w & active;
  assign bus.ea     = ea_w & active;
  assign bus.su     = su_w & active;
  assign bus.eu     = eu_w & active;
  assign bus.tstate = tstate_q;
  assign bus.halt   = halt_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, each instruction's control words, halt and single-step.
module tb_control_sequencer;
  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] LM = 12'h200;
  localparam logic [11:0] CE = 12'h100;
  localparam logic [11:0] LI = 12'h080;
  localparam logic [11:0] EI = 12'h040;
  localparam logic [11:0] LA = 12'h020;
  localparam logic [11:0] EA = 12'h010;
  localparam logic [11:0] SU = 12'h008;
  localparam logic [11:0] EU = 12'h004;
  localparam logic [11:0] LB = 12'h002;
  localparam logic [11:0] LO = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   failures = 0;

  control_sequencer_if bus();
  control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] word();
    return {bus.cp, bus.ep, bus.lm, bus.ce, bus.li, bus.ei,
            bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo};
  endfunction

  task automatic expect_state(input string tag, input logic [5:0] t, input logic h, input logic [11:0] w);
    check({tag, "_tstate"}, 16'(bus.tstate), 16'(t));
    check({tag, "_halt"}, 16'(bus.halt), 16'(h));
    check({tag, "_word"}, 16'(word()), 16'(w));
  endtask

  // ws packs six control words, T1 in the low 12 bits.
  task automatic run_instr(input logic [3:0] op, input logic [71:0] ws, input string tag);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) bus.opcode = op;
      #1;
      expect_state($sformatf("%s_T%0d", tag, i + 1), 6'(1 << i), 1'b0, ws[12*i +: 12]);
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.opcode = 4'h0;
    bus.step_en = 1'b0;
    bus.step = 1'b0;
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;

    // Run into T3, then reset mid-instruction.
    @(negedge clk); #1;
    expect_state("pre_T1", 6'b000001, 1'b0, EP | LM);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1 expect_state("clr_async", 6'b000001, 1'b0, NONE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      expect_state($sformatf("clr_hold%0d", i), 6'b000001, 1'b0, NONE);
    end
    @(posedge clk);
    #2 clr = 1'b0;

    run_instr(4'h0, {NONE, CE | LA, LM | EI, CE | LI, CP, EP | LM}, "lda");
    run_instr(4'h1, {LA | EU, CE | LB, LM | EI, CE | LI, CP, EP | LM}, "add");
    run_instr(4'h2, {LA | SU | EU, CE | LB, LM | EI, CE | LI, CP, EP | LM}, "sub");
    run_instr(4'hE, {NONE, NONE, EA | LO, CE | LI, CP, EP | LM}, "out");
    run_instr(4'h7, {NONE, NONE, NONE, CE | LI, CP, EP | LM}, "nop");

    // HLT: fetch, then T4 with no controls; halt sets on the edge ending T4.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) bus.opcode = 4'hF;
      #1;
      expect_state($sformatf("hlt_T%0d", i + 1), 6'(1 << i),
                   1'b0, (i == 0) ? (EP | LM) : (i == 1) ? CP : (i == 2) ? (CE | LI) : NONE);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.step = ~bus.step;
      if (i % 3 == 0) bus.step_en = ~bus.step_en;
      #1;
      expect_state($sformatf("halted%0d", i), 6'b001000, 1'b1, NONE);
    end
    @(negedge clk);
    clr = 1'b1;
    #1 expect_state("hlt_clr", 6'b000001, 1'b0, NONE);
    @(posedge clk);
    #2;
    clr = 1'b0;
    bus.step = 1'b0;
    bus.step_en = 1'b1;
    bus.opcode = 4'h0;

    // Single step.
    @(negedge clk); #1;
    expect_state("ss_T1_idle", 6'b000001, 1'b0, EP);
    @(negedge clk); bus.step = 1'b1; #1;
    expect_state("ss_T1_adv", 6'b000001, 1'b0, EP | LM);
    @(negedge clk); bus.step = 1'b0; #1;
    expect_state("ss_T2_idle", 6'b000010, 1'b0, NONE);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.step = 1'b1; #1;
      if (i == 0) expect_state("ss_T2_adv", 6'b000010, 1'b0, CP);
      else        expect_state($sformatf("ss_T3_held%0d", i), 6'b000100, 1'b0, CE);
    end
    @(negedge clk); bus.step = 1'b0; #1;
    expect_state("ss_T3_low", 6'b000100, 1'b0, CE);
    @(negedge clk); bus.step = 1'b1; #1;
    expect_state("ss_T3_adv", 6'b000100, 1'b0, CE | LI);
    @(negedge clk); #1;
    expect_state("ss_T4_held", 6'b001000, 1'b0, EI);
    @(negedge clk); bus.step_en = 1'b0; #1;
    expect_state("ss_T4_free", 6'b001000, 1'b0, LM | EI);
    @(negedge clk); #1;
    expect_state("ss_T5_free", 6'b010000, 1'b0, CE | LA);
    @(negedge clk); bus.step = 1'b0; #1;
    expect_state("ss_T6_free", 6'b100000, 1'b0, NONE);
    @(negedge clk); #1;
    expect_state("ss_T1_wrap", 6'b000001, 1'b0, EP | LM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
